// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle CPU control sequencer.
// The optional JAL decode and link strobe are built only when the JAL_EN macro is defined.
// Outputs decode from the current state, plus the stall input that gates the write strobes.
module cpu_control_fsm #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned FLAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [FLAG_W-1:0]  flagModuleOut,
    input  logic               stall,
    output logic               PC_enable,
    output logic               R_enable,
    output logic               LScntl,
    output logic               ALU_Mux_cntl,
    output logic               WE,
    output logic               irenable,
    output logic [1:0]         PC_mux,
    output logic               link_en,
    output logic [3:0]         state_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 16;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC      = 4'd2,
        S_STORE     = 4'd3,
        S_LOAD_ADDR = 4'd4,
        S_LOAD_WB   = 4'd5,
        S_BRANCH    = 4'd6,
        S_JUMP      = 4'd7,
        S_WAIT      = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             from_store_q, from_store_d;
`ifdef JAL_EN
    logic             jal_q, jal_d;
`endif

    logic [OP_W-1:0]  op;
    logic             flag_c, flag_l, flag_f, flag_z, flag_n;
    logic             is_mem_grp, is_load, is_store, is_jcond, is_bcond, is_jal;
    logic             cond_true;
    logic             unused_bits;

    // Opcode field and flag aliases
    assign op          = instruction[INSTR_W-1 -: OP_W];
    assign flag_c      = flagModuleOut[0];
    assign flag_l      = flagModuleOut[1];
    assign flag_f      = flagModuleOut[2];
    assign flag_z      = flagModuleOut[3];
    assign flag_n      = flagModuleOut[4];
    assign unused_bits = ^{instruction, flagModuleOut};

    // Instruction class decode
    assign is_mem_grp = (op[15:12] == 4'b0100);
    assign is_load    = is_mem_grp && (op[7:4] == 4'b0000);
    assign is_store   = is_mem_grp && (op[7:4] == 4'b0100);
    assign is_jcond   = is_mem_grp && (op[7:4] == 4'b1100);
    assign is_bcond   = (op[15:12] == 4'b1100);
`ifdef JAL_EN
    assign is_jal     = is_mem_grp && (op[7:4] == 4'b1000);
`else
    assign is_jal     = 1'b0;
`endif

    // Condition code evaluation
    always_comb begin
        cond_true = 1'b0;
        case (op[11:8])
            4'h0: cond_true = flag_z;
            4'h1: cond_true = !flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = !flag_c;
            4'h4: cond_true = flag_l;
            4'h5: cond_true = !flag_l;
            4'h6: cond_true = flag_n;
            4'h7: cond_true = !flag_n;
            4'h8: cond_true = flag_f;
            4'h9: cond_true = !flag_f;
            4'hA: cond_true = !flag_l && !flag_z;
            4'hB: cond_true = flag_l || flag_z;
            4'hC: cond_true = !flag_n && !flag_z;
            4'hD: cond_true = flag_n || flag_z;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // State, wait counter and context registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            cnt_q        <= '0;
            from_store_q <= 1'b0;
`ifdef JAL_EN
            jal_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            from_store_q <= from_store_d;
`ifdef JAL_EN
            jal_q        <= jal_d;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        from_store_d = from_store_q;
`ifdef JAL_EN
        jal_d        = jal_q;
`endif
        PC_enable    = 1'b0;
        R_enable     = 1'b0;
        LScntl       = 1'b0;
        ALU_Mux_cntl = 1'b0;
        WE           = 1'b0;
        irenable     = 1'b0;
        PC_mux       = 2'b00;
        link_en      = 1'b0;

        case (state_q)
            S_FETCH: begin
                LScntl       = 1'b1;
                ALU_Mux_cntl = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                LScntl = 1'b1;
`ifdef JAL_EN
                jal_d  = is_jal;
`endif
                if (is_load) begin
                    state_d = S_LOAD_ADDR;
                end else if (is_store) begin
                    state_d = S_STORE;
                end else if ((is_jcond && cond_true) || is_jal) begin
                    state_d = S_JUMP;
                end else if (is_bcond && cond_true) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                PC_enable    = 1'b1;
                R_enable     = 1'b1;
                ALU_Mux_cntl = 1'b1;
                irenable     = 1'b1;
                LScntl       = 1'b1;
                state_d      = S_FETCH;
            end
            S_STORE: begin
                PC_enable = 1'b1;
                WE        = 1'b1;
                irenable  = 1'b1;
                if (MEM_LAT > 0) begin
                    state_d      = S_WAIT;
                    cnt_d        = '0;
                    from_store_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD_ADDR: begin
                irenable = 1'b1;
                if (MEM_LAT > 0) begin
                    state_d      = S_WAIT;
                    cnt_d        = '0;
                    from_store_d = 1'b0;
                end else begin
                    state_d = S_LOAD_WB;
                end
            end
            S_WAIT: begin
                // Mirror the memory state that entered the wait, without the write strobe
                PC_enable = from_store_q;
                irenable  = 1'b1;
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    state_d = from_store_q ? S_FETCH : S_LOAD_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_WB: begin
                PC_enable = 1'b1;
                R_enable  = 1'b1;
                irenable  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                PC_enable = 1'b1;
                PC_mux    = 2'b01;
                irenable  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PC_enable = 1'b1;
                PC_mux    = 2'b10;
                irenable  = 1'b1;
`ifdef JAL_EN
                if (jal_q) begin
                    link_en      = 1'b1;
                    R_enable     = 1'b1;
                    ALU_Mux_cntl = 1'b1;
                end
`endif
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase

        // External hold freezes sequencing and suppresses all write strobes
        if (stall) begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            from_store_d = from_store_q;
`ifdef JAL_EN
            jal_d        = jal_q;
`endif
            PC_enable    = 1'b0;
            R_enable     = 1'b0;
            WE           = 1'b0;
            link_en      = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: two instances (MEM_LAT=0 and MEM_LAT=2) driven by directed
// and random instructions, checked cycle by cycle against a per-instruction state-trace model.
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst2, stall0, stall2;
    logic [15:0] instr0, instr2;
    logic [4:0]  flags0, flags2;
    logic        pe0, re0, ls0, alu0, we0, ir0, lk0;
    logic        pe2, re2, ls2, alu2, we2, ir2, lk2;
    logic [1:0]  pm0, pm2;
    logic [3:0]  st0, st2;
    logic [8:0]  out0, out2;

    int errors = 0;
    int checks = 0;

    int exp_seq[$];
    bit ctx_store;
    bit ctx_jal;

    cpu_control_fsm #(.INSTR_W(16), .MEM_LAT(0), .FLAG_W(5)) dut0 (
        .clk(clk), .rst(rst0), .instruction(instr0), .flagModuleOut(flags0), .stall(stall0),
        .PC_enable(pe0), .R_enable(re0), .LScntl(ls0), .ALU_Mux_cntl(alu0), .WE(we0),
        .irenable(ir0), .PC_mux(pm0), .link_en(lk0), .state_o(st0)
    );

    cpu_control_fsm #(.INSTR_W(16), .MEM_LAT(2), .FLAG_W(5)) dut2 (
        .clk(clk), .rst(rst2), .instruction(instr2), .flagModuleOut(flags2), .stall(stall2),
        .PC_enable(pe2), .R_enable(re2), .LScntl(ls2), .ALU_Mux_cntl(alu2), .WE(we2),
        .irenable(ir2), .PC_mux(pm2), .link_en(lk2), .state_o(st2)
    );

    // Output bundle: {PC_enable, R_enable, LScntl, ALU_Mux_cntl, WE, irenable, PC_mux, link_en}
    assign out0 = {pe0, re0, ls0, alu0, we0, ir0, pm0, lk0};
    assign out2 = {pe2, re2, ls2, alu2, we2, ir2, pm2, lk2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] cc, input logic [4:0] f);
        bit c, l, fl, z, n;
        bit tbl[16];
        c = f[0]; l = f[1]; fl = f[2]; z = f[3]; n = f[4];
        tbl = '{z, !z, c, !c, l, !l, n, !n, fl, !fl,
                !l && !z, l || z, !n && !z, n || z, 1'b1, 1'b0};
        return tbl[cc];
    endfunction

    // Expected outputs for a state number, given instruction context and stall
    function automatic logic [8:0] exp_out(input int st, input bit is_st, input bit is_jal, input bit stl);
        logic pe, re, ls, alu, we, ir, lk;
        logic [1:0] pm;
        pe = 0; re = 0; ls = 0; alu = 0; we = 0; ir = 0; lk = 0; pm = 2'b00;
        case (st)
            0: begin ls = 1; alu = 1; end
            1: ls = 1;
            2: begin pe = 1; re = 1; alu = 1; ir = 1; ls = 1; end
            3: begin pe = 1; we = 1; ir = 1; end
            4: ir = 1;
            5: begin pe = 1; re = 1; ir = 1; end
            6: begin pe = 1; pm = 2'b01; ir = 1; end
            7: begin
                pe = 1; pm = 2'b10; ir = 1;
                if (is_jal) begin lk = 1; re = 1; alu = 1; end
            end
            8: begin ir = 1; pe = is_st; end
            default: ;
        endcase
        if (stl) begin pe = 0; re = 0; we = 0; lk = 0; end
        return {pe, re, ls, alu, we, ir, pm, lk};
    endfunction

    // Build the expected state trace of one instruction, starting at FETCH
    task automatic plan(input logic [15:0] ins, input logic [4:0] fl, input int lat);
        logic [3:0] hi, cc, mid;
        hi = ins[15:12]; cc = ins[11:8]; mid = ins[7:4];
        exp_seq.delete();
        exp_seq.push_back(0);
        exp_seq.push_back(1);
        ctx_store = 0;
        ctx_jal   = 0;
        if (hi == 4'h4 && mid == 4'h0) begin
            exp_seq.push_back(4);
            for (int k = 0; k < lat; k++) exp_seq.push_back(8);
            exp_seq.push_back(5);
        end else if (hi == 4'h4 && mid == 4'h4) begin
            ctx_store = 1;
            exp_seq.push_back(3);
            for (int k = 0; k < lat; k++) exp_seq.push_back(8);
        end else if (hi == 4'h4 && mid == 4'hC && cond_ok(cc, fl)) begin
            exp_seq.push_back(7);
        end else if (hi == 4'hC && cond_ok(cc, fl)) begin
            exp_seq.push_back(6);
`ifdef JAL_EN
        end else if (hi == 4'h4 && mid == 4'h8) begin
            ctx_jal = 1;
            exp_seq.push_back(7);
`endif
        end else begin
            exp_seq.push_back(2);
        end
    endtask

    task automatic set_stall(input int d, input logic s);
        if (d == 0) stall0 = s; else stall2 = s;
    endtask

    // Run one instruction on DUT d from FETCH back to FETCH; entered and left just after a rising edge
    task automatic run_instr(input int d, input logic [15:0] ins, input logic [4:0] fl,
                             input bit rnd, input int hold_st, input int hold_n, output int we_cycles);
        int i, held;
        bit s;
        logic [8:0] obs;
        logic [3:0] so;
        plan(ins, fl, (d == 0) ? 0 : 2);
        if (d == 0) begin instr0 = ins; flags0 = fl; end
        else begin instr2 = ins; flags2 = fl; end
        i = 0; held = 0; we_cycles = 0;
        while (i < exp_seq.size()) begin
            s = 0;
            if (rnd && $urandom_range(3) == 0) s = 1;
            if (exp_seq[i] == hold_st && held < hold_n) begin s = 1; held++; end
            set_stall(d, s);
            #1;
            so  = (d == 0) ? st0 : st2;
            obs = (d == 0) ? out0 : out2;
            check_eq($sformatf("dut%0d ins=%h step%0d state", d * 2, ins, i), 32'(so), 32'(exp_seq[i]));
            check_eq($sformatf("dut%0d ins=%h step%0d outs", d * 2, ins, i), 32'(obs),
                     32'(exp_out(exp_seq[i], ctx_store, ctx_jal, s)));
            if (obs[4]) we_cycles++;
            @(posedge clk); #1;
            if (!s) i++;
        end
        set_stall(d, 1'b1);
    endtask

    initial begin
        int wc;
        logic [15:0] ins;
        logic [3:0] cc, mid, lo;
        int d;

        rst0 = 0; rst2 = 0; stall0 = 1; stall2 = 1;
        instr0 = '0; instr2 = '0; flags0 = '0; flags2 = '0;

        // Reset state, asserted between edges
        #12;
        check_eq("reset dut0 state", 32'(st0), 32'd0);
        check_eq("reset dut0 outs", 32'(out0), 32'(exp_out(0, 0, 0, 1)));
        check_eq("reset dut2 state", 32'(st2), 32'd0);
        check_eq("reset dut2 outs", 32'(out2), 32'(exp_out(0, 0, 0, 1)));
        @(negedge clk);
        rst0 = 1; rst2 = 1;
        @(posedge clk); #1;
        check_eq("stalled fetch holds", 32'(st0), 32'd0);

        // Directed instructions
        run_instr(0, 16'h0105, 5'b00000, 0, -1, 0, wc);
        run_instr(1, 16'h4102, 5'b00000, 0, -1, 0, wc);
        check_eq("load WE cycles", 32'(wc), 32'd0);
        run_instr(0, 16'h4102, 5'b00000, 0, -1, 0, wc);
        run_instr(0, 16'hC005, 5'b01000, 0, -1, 0, wc);
        run_instr(0, 16'hC005, 5'b00000, 0, -1, 0, wc);
        run_instr(0, 16'h4143, 5'b00000, 0, 3, 3, wc);
        check_eq("store stalled WE cycles", 32'(wc), 32'd1);
        run_instr(1, 16'h4143, 5'b00000, 0, 8, 2, wc);
        check_eq("store lat2 WE cycles", 32'(wc), 32'd1);
        run_instr(0, 16'h4EC3, 5'b00000, 0, -1, 0, wc);
        run_instr(0, 16'h4083, 5'b00000, 0, -1, 0, wc);
        run_instr(1, 16'h4083, 5'b11111, 0, 7, 2, wc);

        // Reset mid-LOAD_ADDR, between edges
        instr2 = 16'h4102; stall2 = 0;
        @(posedge clk); #1;
        check_eq("rstload decode", 32'(st2), 32'd1);
        @(posedge clk); #1;
        check_eq("rstload addr", 32'(st2), 32'd4);
        #2 rst2 = 0;
        #1;
        check_eq("rstload async state", 32'(st2), 32'd0);
        check_eq("rstload async outs", 32'(out2), 32'(exp_out(0, 0, 0, 0)));
        #2 rst2 = 1;
        @(posedge clk); #1;
        check_eq("first edge after reset", 32'(st2), 32'd1);
        stall2 = 1; rst2 = 0;
        #2 rst2 = 1;
        @(posedge clk); #1;
        check_eq("reparked dut2", 32'(st2), 32'd0);

        // Reset in STORE drops WE without a clock edge
        instr0 = 16'h4143; stall0 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rststore in store", 32'(st0), 32'd3);
        check_eq("rststore WE high", 32'(we0), 32'd1);
        #2 rst0 = 0;
        #1;
        check_eq("rststore WE async", 32'(we0), 32'd0);
        check_eq("rststore state async", 32'(st0), 32'd0);
        stall0 = 1;
        #2 rst0 = 1;
        @(posedge clk); #1;

        // Random instructions, flags and stalls
        for (int n = 0; n < 300; n++) begin
            d   = int'($urandom_range(1));
            cc  = 4'($urandom);
            mid = 4'($urandom);
            lo  = 4'($urandom);
            case ($urandom_range(5))
                0: ins = {4'h4, cc, 4'h0, lo};
                1: ins = {4'h4, cc, 4'h4, lo};
                2: ins = {4'h4, cc, 4'hC, lo};
                3: ins = {4'h4, cc, 4'h8, lo};
                4: ins = {4'hC, cc, mid, lo};
                default: ins = 16'($urandom);
            endcase
            run_instr(d, ins, 5'($urandom), 1, -1, 0, wc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
